// File: rtl/retro16_kbd_pkg.sv
// Shared definitions for the retro16 keyboard buffer: read-word layout,
// status address, receiver state encoding and the frame check helper.
package retro16_kbd_pkg;

    localparam int VALID_BIT = 15;
    localparam int OVF_BIT   = 14;
    localparam int PERR_BIT  = 13;
    localparam int COUNT_LSB = 8;

    localparam logic [15:0] KBD_STATUS_ADDR = 16'h0000;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    // A frame is good when the stop bit is high and data plus parity hold an odd count of ones.
    function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
        return stop & (^{data, par});
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, clock glitch filter,
// frame FSM and inter-edge watchdog. Emits one-cycle rx_valid / rx_err pulses.
module ps2_rx
    import retro16_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT_CYCLES);

    logic          clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
    logic          filt_clk_r, filt_clk_s;
    logic [FW-1:0] filt_cnt_r, filt_cnt_s;
    logic          fall_s, timeout_s;
    logic [WW-1:0] wd_cnt_r, wd_cnt_s;
    rx_state_e     state_r, state_s;
    logic [2:0]    bit_cnt_r, bit_cnt_s;
    logic [7:0]    shift_r, shift_s, rx_byte_r;
    logic          par_r, par_s, valid_s, err_s, rx_valid_r, rx_err_r;

    // Two-flop synchronisers; both pins idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Filtered clock flips only after the synchronised level has disagreed for FILTER_LEN cycles.
    always_comb begin
        filt_clk_s = filt_clk_r;
        filt_cnt_s = '0;
        if (clk_sync_r != filt_clk_r) begin
            if (filt_cnt_r == FILT_LAST) begin
                filt_clk_s = clk_sync_r;
                filt_cnt_s = '0;
            end else begin
                filt_cnt_s = filt_cnt_r + FW'(1);
            end
        end else begin
            filt_cnt_s = '0;
        end
        fall_s = filt_clk_r & ~filt_clk_s;
    end

    // Watchdog restarts on each falling edge and is held clear while idle.
    always_comb begin
        wd_cnt_s = wd_cnt_r;
        if ((state_r == RX_IDLE) || fall_s) begin
            wd_cnt_s = '0;
        end else if (wd_cnt_r != WD_MAX) begin
            wd_cnt_s = wd_cnt_r + WW'(1);
        end else begin
            wd_cnt_s = wd_cnt_r;
        end
    end

    // Frame FSM next state; the watchdog expiring overrides any edge activity.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        par_s     = par_r;
        valid_s   = 1'b0;
        err_s     = 1'b0;
        timeout_s = (state_r != RX_IDLE) && !fall_s && (wd_cnt_r == WD_MAX);
        if (timeout_s) begin
            state_s = RX_IDLE;
            err_s   = 1'b1;
        end else if (fall_s) begin
            case (state_r)
                RX_IDLE: begin
                    if (!data_sync_r) begin
                        state_s   = RX_DATA;
                        bit_cnt_s = 3'd0;
                    end else begin
                        state_s = RX_IDLE;
                    end
                end
                RX_DATA: begin
                    shift_s   = {data_sync_r, shift_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_s = RX_PARITY;
                    end else begin
                        state_s = RX_DATA;
                    end
                end
                RX_PARITY: begin
                    par_s   = data_sync_r;
                    state_s = RX_STOP;
                end
                RX_STOP: begin
                    state_s = RX_IDLE;
                    if (frame_ok(shift_r, par_r, data_sync_r)) begin
                        valid_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: begin
                    state_s = RX_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Filter, watchdog, FSM and output pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk_r <= 1'b1;
            filt_cnt_r <= '0;
            wd_cnt_r   <= '0;
            state_r    <= RX_IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            par_r      <= 1'b0;
            rx_byte_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
        end else begin
            filt_clk_r <= filt_clk_s;
            filt_cnt_r <= filt_cnt_s;
            wd_cnt_r   <= wd_cnt_s;
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            par_r      <= par_s;
            rx_byte_r  <= valid_s ? shift_r : rx_byte_r;
            rx_valid_r <= valid_s;
            rx_err_r   <= err_s;
        end
    end

    assign rx_byte  = rx_byte_r;
    assign rx_valid = rx_valid_r;
    assign rx_err   = rx_err_r;

endmodule

// File: rtl/ps2_keyboard_buffer.sv
// Keyboard data word at the controller's I/O address: PS/2 receiver feeding
// a 16-entry scancode FIFO, with head byte and sticky status in one read word.
module ps2_keyboard_buffer
    import retro16_kbd_pkg::*;
#(
    parameter int FIFO_AW        = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FILTER_LEN     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [15:0] kbd_ram_addr,
    input  logic        kbd_pop,
    output logic [15:0] kbd_ram_data,
    output logic        frame_error
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    logic [7:0]       rx_byte_s;
    logic             rx_valid_s, rx_err_s;
    logic [7:0]       mem_r [DEPTH];
    logic [FIFO_AW:0] wr_ptr_r, rd_ptr_r, count_s;
    logic             empty_s, full_s, pop_req_s, pop_s, push_s, drop_s;
    logic             ovf_r, ovf_s, perr_r, perr_s;
    logic [7:0]       head_s;
    logic [15:0]      rd_word_s, kbd_ram_data_r;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FILTER_LEN     (FILTER_LEN)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte_s),
        .rx_valid (rx_valid_s),
        .rx_err   (rx_err_s)
    );

    // FIFO control; a pop frees the slot so a push while full still lands.
    always_comb begin
        count_s   = wr_ptr_r - rd_ptr_r;
        empty_s   = (count_s == '0);
        full_s    = (count_s == FULL_COUNT);
        pop_req_s = kbd_pop && (kbd_ram_addr == KBD_STATUS_ADDR);
        pop_s     = pop_req_s && !empty_s;
        push_s    = rx_valid_s && (!full_s || pop_s);
        drop_s    = rx_valid_s && full_s && !pop_s;
        head_s    = empty_s ? 8'h00 : mem_r[rd_ptr_r[FIFO_AW-1:0]];
    end

    // Sticky flags: a new error wins over a clearing pop in the same cycle.
    always_comb begin
        ovf_s  = ovf_r;
        perr_s = perr_r;
        if (drop_s) begin
            ovf_s = 1'b1;
        end else if (pop_req_s) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = ovf_r;
        end
        if (rx_err_s) begin
            perr_s = 1'b1;
        end else if (pop_req_s) begin
            perr_s = 1'b0;
        end else begin
            perr_s = perr_r;
        end
    end

    // Read word assembly from the pre-update FIFO state.
    always_comb begin
        rd_word_s = 16'h0000;
        if (kbd_ram_addr == KBD_STATUS_ADDR) begin
            rd_word_s[VALID_BIT]        = !empty_s;
            rd_word_s[OVF_BIT]          = ovf_r;
            rd_word_s[PERR_BIT]         = perr_r;
            rd_word_s[COUNT_LSB +: 5]   = 5'(count_s);
            rd_word_s[7:0]              = head_s;
        end else begin
            rd_word_s = 16'h0000;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r[FIFO_AW-1:0]] <= rx_byte_s;
        end
    end

    // Pointers, flags and the registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            ovf_r          <= 1'b0;
            perr_r         <= 1'b0;
            kbd_ram_data_r <= 16'h0000;
        end else begin
            wr_ptr_r       <= push_s ? wr_ptr_r + (FIFO_AW + 1)'(1) : wr_ptr_r;
            rd_ptr_r       <= pop_s  ? rd_ptr_r + (FIFO_AW + 1)'(1) : rd_ptr_r;
            ovf_r          <= ovf_s;
            perr_r         <= perr_s;
            kbd_ram_data_r <= rd_word_s;
        end
    end

    assign kbd_ram_data = kbd_ram_data_r;
    assign frame_error  = rx_err_s;

endmodule

// File: tb/tb_ps2_keyboard_buffer.sv
// Directed bench for ps2_keyboard_buffer: bit-banged PS/2 frames, table-driven
// read/pop vectors and hand sequences for timeout, overflow and reset corners.
module tb_ps2_keyboard_buffer;

    localparam int TO   = 300;
    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] kbd_ram_addr = 16'h0000;
    logic        kbd_pop = 1'b0;
    logic [15:0] kbd_ram_data;
    logic        frame_error;

    int total = 0;
    int bad = 0;
    int fe_cnt = 0;

    typedef struct {
        logic [15:0] addr;
        logic        pop;
        logic [15:0] exp;
    } vec_t;

    vec_t drain_tbl [16];
    vec_t addr_tbl [6];

    ps2_keyboard_buffer #(
        .FIFO_AW        (4),
        .TIMEOUT_CYCLES (TO),
        .FILTER_LEN     (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .kbd_ram_addr (kbd_ram_addr),
        .kbd_pop      (kbd_pop),
        .kbd_ram_data (kbd_ram_data),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && frame_error) fe_cnt <= fe_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One bus cycle: drive address/pop, return the word registered at that edge.
    task automatic access(input logic [15:0] a, input logic p, output logic [15:0] w);
        kbd_ram_addr = a;
        kbd_pop = p;
        cyc(1);
        kbd_pop = 1'b0;
        w = kbd_ram_data;
    endtask

    task automatic read_chk(input string name, input logic [15:0] a, input logic p,
                            input logic [15:0] exp);
        logic [15:0] w;
        access(a, p, w);
        check(name, w, exp);
    endtask

    // Bit-bang nbits of a frame; optionally pop in the exact cycle the stop-bit push lands.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits,
                              input logic pop_at_stop);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            cyc(HALF);
            ps2_clk = 1'b0;
            if (i == 10 && pop_at_stop) begin
                cyc(6);
                kbd_pop = 1'b1;
                cyc(1);
                kbd_pop = 1'b0;
                cyc(HALF - 7);
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        cyc(HALF);
    endtask

    initial begin
        int fe0;
        logic [15:0] w;

        for (int k = 0; k < 16; k++) begin
            drain_tbl[k].addr = 16'h0000;
            drain_tbl[k].pop  = 1'b1;
            drain_tbl[k].exp  = 16'h8000 | ((k == 0) ? 16'h4000 : 16'h0000)
                              | (16'(16 - k) << 8) | 16'(k);
        end
        addr_tbl[0] = '{16'h0001, 1'b0, 16'h0000};
        addr_tbl[1] = '{16'hC000, 1'b0, 16'h0000};
        addr_tbl[2] = '{16'hFFFF, 1'b0, 16'h0000};
        addr_tbl[3] = '{16'h0001, 1'b1, 16'h0000};
        addr_tbl[4] = '{16'h0000, 1'b0, 16'h815A};
        addr_tbl[5] = '{16'h8000, 1'b1, 16'h0000};

        // Reset state
        cyc(3);
        check("reset_data", kbd_ram_data, 16'h0000);
        check("reset_ferr", 16'(frame_error), 16'h0000);
        rst_n = 1'b1;
        cyc(5);
        read_chk("idle_read", 16'h0000, 1'b0, 16'h0000);

        // Valid 0x1C, then pop
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        read_chk("frame_1c", 16'h0000, 1'b0, 16'h811C);
        read_chk("pop_1c", 16'h0000, 1'b1, 16'h811C);
        read_chk("after_pop_1c", 16'h0000, 1'b0, 16'h0000);

        // Bad parity
        fe0 = fe_cnt;
        send_frame(8'h1C, 1'b1, 11, 1'b0);
        check("parity_ferr_count", 16'(fe_cnt - fe0), 16'd1);
        read_chk("parity_perr", 16'h0000, 1'b0, 16'h2000);
        read_chk("parity_pop", 16'h0000, 1'b1, 16'h2000);
        read_chk("parity_cleared", 16'h0000, 1'b0, 16'h0000);

        // 17 frames with no pop: overflow
        fe0 = fe_cnt;
        for (int k = 0; k < 17; k++) send_frame(8'(k), 1'b0, 11, 1'b0);
        check("ovf_no_ferr", 16'(fe_cnt - fe0), 16'd0);
        read_chk("ovf_full", 16'h0000, 1'b0, 16'hD000);
        for (int k = 0; k < 16; k++) begin
            access(drain_tbl[k].addr, drain_tbl[k].pop, w);
            check($sformatf("drain_%0d", k), w, drain_tbl[k].exp);
        end
        read_chk("drained", 16'h0000, 1'b0, 16'h0000);

        // Watchdog timeout mid-frame
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, 4, 1'b0);
        check("pre_timeout_ferr", 16'(fe_cnt - fe0), 16'd0);
        cyc(TO + 50);
        check("timeout_ferr_count", 16'(fe_cnt - fe0), 16'd1);
        read_chk("timeout_perr", 16'h0000, 1'b1, 16'h2000);
        read_chk("timeout_cleared", 16'h0000, 1'b0, 16'h0000);
        send_frame(8'hF0, 1'b0, 11, 1'b0);
        read_chk("after_timeout_f0", 16'h0000, 1'b1, 16'h81F0);
        read_chk("f0_popped", 16'h0000, 1'b0, 16'h0000);

        // Full FIFO with pop coinciding with push
        for (int k = 0; k < 16; k++) send_frame(8'h20 + 8'(k), 1'b0, 11, 1'b0);
        read_chk("full_again", 16'h0000, 1'b0, 16'h9020);
        send_frame(8'h30, 1'b0, 11, 1'b1);
        read_chk("pop_push_full", 16'h0000, 1'b0, 16'h9021);
        for (int k = 0; k < 16; k++) begin
            logic [7:0] hb;
            hb = (k < 15) ? 8'h21 + 8'(k) : 8'h30;
            read_chk($sformatf("pp_drain_%0d", k), 16'h0000, 1'b1,
                     16'h8000 | (16'(16 - k) << 8) | 16'(hb));
        end
        read_chk("pp_drained", 16'h0000, 1'b0, 16'h0000);

        // Reset mid-frame
        send_frame(8'hA5, 1'b0, 5, 1'b0);
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(10);
        read_chk("post_reset", 16'h0000, 1'b0, 16'h0000);
        send_frame(8'h5A, 1'b0, 11, 1'b0);
        read_chk("frame_5a", 16'h0000, 1'b0, 16'h815A);
        for (int k = 0; k < 6; k++) begin
            access(addr_tbl[k].addr, addr_tbl[k].pop, w);
            check($sformatf("addr_vec_%0d", k), w, addr_tbl[k].exp);
        end
        read_chk("non_zero_pop_ignored", 16'h0000, 1'b0, 16'h815A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
